// File: rtl/mcp3008_pkg.sv
// Shared constants and types for the MCP3008 SPI responder.
// Frame states are plain 3-bit constants so the FSM register stays a simple vector.
package mcp3008_pkg;

   localparam int unsigned ADC_CH   = 8;
   localparam int unsigned ADC_BITS = 10;

   typedef logic [ADC_BITS-1:0] adc_word_t;
   typedef logic [2:0]          mcp_state_t;

   localparam mcp_state_t IDLE  = 3'd0;
   localparam mcp_state_t START = 3'd1;
   localparam mcp_state_t CFG   = 3'd2;
   localparam mcp_state_t CONV  = 3'd3;
   localparam mcp_state_t MSB   = 3'd4;
   localparam mcp_state_t LSB   = 3'd5;
   localparam mcp_state_t ZERO  = 3'd6;

endpackage

// File: rtl/spi_in_sync.sv
// Synchronizes the asynchronous SPI pad inputs into clk and detects synced SCLK edges.
// All outputs are registered so that edge strobes and levels stay cycle-aligned.
module spi_in_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic sclr,
   input  logic sclk,
   input  logic csn,
   input  logic mosi,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic csn_lvl,
   output logic mosi_lvl
);

   logic [SYNC_STAGES-1:0] sclk_sr, csn_sr, mosi_sr;
   logic                   sclk_d;

   // Chains clear to 0 so a csn already low at reset release is never seen high (no arming).
   always_ff @(posedge clk) begin
      if (sclr) begin
         sclk_sr   <= '0;
         csn_sr    <= '0;
         mosi_sr   <= '0;
         sclk_d    <= 1'b0;
         sclk_rise <= 1'b0;
         sclk_fall <= 1'b0;
         csn_lvl   <= 1'b0;
         mosi_lvl  <= 1'b0;
      end else begin
         sclk_sr   <= {sclk_sr[SYNC_STAGES-2:0], sclk};
         csn_sr    <= {csn_sr[SYNC_STAGES-2:0], csn};
         mosi_sr   <= {mosi_sr[SYNC_STAGES-2:0], mosi};
         sclk_d    <= sclk_sr[SYNC_STAGES-1];
         sclk_rise <= sclk_sr[SYNC_STAGES-1] & ~sclk_d;
         sclk_fall <= ~sclk_sr[SYNC_STAGES-1] & sclk_d;
         csn_lvl   <= csn_sr[SYNC_STAGES-1];
         mosi_lvl  <= mosi_sr[SYNC_STAGES-1];
      end
   end

endmodule

// File: rtl/mcp3008_responder.sv
// SPI mode 0,0 responder emulating an MCP3008 ADC: decodes the start/config bits and serves
// a snapshotted channel code MSB-first, then LSB-first, then zeros until chip select rises.
module mcp3008_responder #(
   parameter int unsigned ADC_NUM     = 8,
   parameter int unsigned ADC_BITS    = 10,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                              clk,
   input  logic                              sclr,
   input  logic                              sclk,
   input  logic                              csn,
   input  logic                              mosi,
   output logic                              miso,
   output logic                              miso_oe,
   input  logic [ADC_NUM-1:0][ADC_BITS-1:0]  data,
   output logic                              conv,
   output logic [2:0]                        conv_ch,
   output logic                              conv_sgl,
   output logic                              frame_err
);
   import mcp3008_pkg::*;

   localparam logic [3:0] LAST_BIT = 4'(ADC_BITS - 1);

   logic sclk_rise, sclk_fall, csn_s, mosi_s;

   spi_in_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk       (clk),
      .sclr      (sclr),
      .sclk      (sclk),
      .csn       (csn),
      .mosi      (mosi),
      .sclk_rise (sclk_rise),
      .sclk_fall (sclk_fall),
      .csn_lvl   (csn_s),
      .mosi_lvl  (mosi_s)
   );

   mcp_state_t          state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [3:0]          cfg_q, cfg_d, cfg_nxt;
   logic [ADC_BITS-1:0] snap_q, snap_d;
   logic                miso_q, miso_d, oe_q, oe_d, conv_q, conv_d;
   logic [2:0]          ch_q, ch_d;
   logic                sgl_q, sgl_d, ferr_q, ferr_d, armed_q, armed_d;

   logic [ADC_BITS-1:0] in_pos, in_neg, code;
   logic [ADC_BITS:0]   diff;

   // Code is evaluated from the config word as it will look after the current shift.
   assign cfg_nxt = {cfg_q[2:0], mosi_s};

   always_comb begin
      in_pos = data[cfg_nxt[2:0]];
      in_neg = data[{cfg_nxt[2:1], ~cfg_nxt[0]}];
      diff   = {1'b0, in_pos} - {1'b0, in_neg};
      if (cfg_nxt[3])          code = in_pos;
      else if (diff[ADC_BITS]) code = '0;
      else                     code = diff[ADC_BITS-1:0];
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cfg_d   = cfg_q;
      snap_d  = snap_q;
      miso_d  = miso_q;
      oe_d    = oe_q;
      conv_d  = 1'b0;
      ch_d    = ch_q;
      sgl_d   = sgl_q;
      ferr_d  = 1'b0;
      armed_d = armed_q;
      if (csn_s) begin
         // Chip select high overrides any same-cycle sclk edge.
         armed_d = 1'b1;
         if (state_q != IDLE) begin
            state_d = IDLE;
            miso_d  = 1'b0;
            oe_d    = 1'b0;
            ferr_d  = (state_q == CFG) || (state_q == CONV) || (state_q == MSB);
         end
      end else begin
         case (state_q)
            IDLE: if (armed_q) begin
               state_d = START;
               oe_d    = 1'b1;
               miso_d  = 1'b0;
            end
            START: if (sclk_rise && mosi_s) begin
               state_d = CFG;
               cnt_d   = '0;
            end
            CFG: if (sclk_rise) begin
               cfg_d = cfg_nxt;
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd3) begin
                  state_d = CONV;
                  conv_d  = 1'b1;
                  sgl_d   = cfg_nxt[3];
                  ch_d    = cfg_nxt[2:0];
                  snap_d  = code;
               end
            end
            CONV: if (sclk_fall) begin
               state_d = MSB;
               miso_d  = 1'b0;
               cnt_d   = LAST_BIT;
            end
            MSB: if (sclk_fall) begin
               miso_d = snap_q[cnt_q];
               if (cnt_q == 4'd0) begin
                  state_d = LSB;
                  cnt_d   = 4'd1;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
            LSB: if (sclk_fall) begin
               miso_d = snap_q[cnt_q];
               if (cnt_q == LAST_BIT) state_d = ZERO;
               else                   cnt_d   = cnt_q + 4'd1;
            end
            ZERO: if (sclk_fall) miso_d = 1'b0;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (sclr) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         cfg_q   <= '0;
         snap_q  <= '0;
         miso_q  <= 1'b0;
         oe_q    <= 1'b0;
         conv_q  <= 1'b0;
         ch_q    <= '0;
         sgl_q   <= 1'b0;
         ferr_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cfg_q   <= cfg_d;
         snap_q  <= snap_d;
         miso_q  <= miso_d;
         oe_q    <= oe_d;
         conv_q  <= conv_d;
         ch_q    <= ch_d;
         sgl_q   <= sgl_d;
         ferr_q  <= ferr_d;
         armed_q <= armed_d;
      end
   end

   assign miso      = miso_q;
   assign miso_oe   = oe_q;
   assign conv      = conv_q;
   assign conv_ch   = ch_q;
   assign conv_sgl  = sgl_q;
   assign frame_err = ferr_q;

endmodule

// File: tb/tb_mcp3008_responder.sv
// Bench for mcp3008_responder: a mode-0 SPI master task plus a table of frames with
// hand-computed codes, followed by abort, data-change and mid-frame reset sequences.
module tb_mcp3008_responder;

   localparam int HALF = 36;

   logic            clk = 1'b0;
   logic            sclr, sclk, csn, mosi;
   logic            miso, miso_oe, conv, conv_sgl, frame_err;
   logic [2:0]      conv_ch;
   logic [7:0][9:0] data;

   int n_checks = 0;
   int n_pass   = 0;
   int conv_cnt = 0;
   int ferr_cnt = 0;

   always #7 clk = ~clk;

   mcp3008_responder #(
      .ADC_NUM     (8),
      .ADC_BITS    (10),
      .SYNC_STAGES (2)
   ) dut (
      .clk       (clk),
      .sclr      (sclr),
      .sclk      (sclk),
      .csn       (csn),
      .mosi      (mosi),
      .miso      (miso),
      .miso_oe   (miso_oe),
      .data      (data),
      .conv      (conv),
      .conv_ch   (conv_ch),
      .conv_sgl  (conv_sgl),
      .frame_err (frame_err)
   );

   always @(posedge clk) begin
      if (conv)      conv_cnt <= conv_cnt + 1;
      if (frame_err) ferr_cnt <= ferr_cnt + 1;
   end

   typedef struct {
      int         lead;
      logic       sgl;
      logic [2:0] ch;
      int         nextra;
      logic [9:0] code;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One SCLK period; master samples miso at the rising edge.
   task automatic sclk_cycle(input logic m, output logic s, output logic oe_s);
      mosi = m;
      wait_clks(HALF);
      sclk = 1'b1;
      s    = miso;
      oe_s = miso_oe;
      wait_clks(HALF);
      sclk = 1'b0;
   endtask

   task automatic send_header(input int lead, input logic sgl, input logic [2:0] ch,
                              output logic all_oe);
      logic [4:0] hdr;
      logic       s, o;
      hdr    = {1'b1, sgl, ch};
      all_oe = 1'b1;
      for (int i = 0; i < lead + 5; i++) begin
         sclk_cycle((i < lead) ? 1'b0 : hdr[4 - (i - lead)], s, o);
         all_oe &= o;
      end
   endtask

   task automatic run_frame(input int lead, input logic sgl, input logic [2:0] ch,
                            input int nextra, output logic [63:0] rx, output logic all_oe,
                            output logic oe_end);
      logic s, o;
      rx   = '0;
      csn  = 1'b0;
      wait_clks(HALF);
      send_header(lead, sgl, ch, all_oe);
      for (int i = 0; i < nextra; i++) begin
         sclk_cycle(1'b0, s, o);
         rx[i] = s;
         all_oe &= o;
      end
      wait_clks(HALF);
      csn = 1'b1;
      wait_clks(4);
      oe_end = miso_oe;
      wait_clks(HALF);
   endtask

   // Null bit, B9..B0, B1..B9, then zeros; truncated to the clocks actually sent.
   function automatic logic [63:0] exp_stream(input logic [9:0] code, input int n);
      logic [63:0] s;
      s = '0;
      for (int k = 0; k < 10; k++) s[1 + k]  = code[9 - k];
      for (int k = 0; k < 9; k++)  s[11 + k] = code[1 + k];
      for (int k = 0; k < 64; k++) if (k >= n) s[k] = 1'b0;
      return s;
   endfunction

   initial begin
      logic [63:0] rx;
      logic        all_oe, oe_end, s, o, seen, or_miso, or_oe;
      int          c0, f0;

      vecs[0] = '{0, 1'b1, 3'd0, 11, 10'h2AA};
      vecs[1] = '{7, 1'b1, 3'd7, 30, 10'h155};
      vecs[2] = '{0, 1'b0, 3'd0, 11, 10'h2A8};
      vecs[3] = '{0, 1'b0, 3'd1, 11, 10'h000};
      vecs[4] = '{2, 1'b1, 3'd4, 20, 10'h005};
      vecs[5] = '{0, 1'b0, 3'd5, 11, 10'h001};
      vecs[6] = '{1, 1'b0, 3'd6, 11, 10'h000};
      vecs[7] = '{0, 1'b0, 3'd7, 24, 10'h14E};

      data = {10'h155, 10'd7, 10'd6, 10'd5, 10'd4, 10'd3, 10'd2, 10'h2AA};
      sclr = 1'b1;
      csn  = 1'b1;
      sclk = 1'b0;
      mosi = 1'b0;
      wait_clks(5);
      check("rst_miso", 64'(miso), 64'd0);
      check("rst_miso_oe", 64'(miso_oe), 64'd0);
      check("rst_conv", 64'(conv), 64'd0);
      check("rst_conv_ch", 64'(conv_ch), 64'd0);
      check("rst_conv_sgl", 64'(conv_sgl), 64'd0);
      check("rst_frame_err", 64'(frame_err), 64'd0);
      sclr = 1'b0;
      wait_clks(HALF);

      for (int v = 0; v < 8; v++) begin
         c0 = conv_cnt;
         f0 = ferr_cnt;
         run_frame(vecs[v].lead, vecs[v].sgl, vecs[v].ch, vecs[v].nextra, rx, all_oe, oe_end);
         check($sformatf("v%0d_stream", v), rx, exp_stream(vecs[v].code, vecs[v].nextra));
         check($sformatf("v%0d_conv_count", v), 64'(conv_cnt - c0), 64'd1);
         check($sformatf("v%0d_conv_ch", v), 64'(conv_ch), 64'(vecs[v].ch));
         check($sformatf("v%0d_conv_sgl", v), 64'(conv_sgl), 64'(vecs[v].sgl));
         check($sformatf("v%0d_oe_in_frame", v), 64'(all_oe), 64'd1);
         check($sformatf("v%0d_oe_after_csn", v), 64'(oe_end), 64'd0);
         check($sformatf("v%0d_no_frame_err", v), 64'(ferr_cnt - f0), 64'd0);
      end

      // Abort after five data bits: state still serving MSB-first bits.
      f0 = ferr_cnt;
      run_frame(0, 1'b1, 3'd0, 6, rx, all_oe, oe_end);
      check("abort_stream", rx, exp_stream(10'h2AA, 6));
      check("abort_frame_err", 64'(ferr_cnt - f0), 64'd1);
      check("abort_oe_off", 64'(oe_end), 64'd0);
      run_frame(0, 1'b1, 3'd1, 11, rx, all_oe, oe_end);
      check("after_abort_ch1", rx, exp_stream(10'd2, 11));

      // Data change right after the conversion strobe must not affect this frame.
      seen = 1'b0;
      fork
         run_frame(0, 1'b1, 3'd3, 11, rx, all_oe, oe_end);
         begin
            for (int i = 0; i < 5000 && !seen; i++) begin
               @(negedge clk);
               if (conv) seen = 1'b1;
            end
            data[3] = 10'h3FF;
         end
      join
      check("snap_conv_seen", 64'(seen), 64'd1);
      check("snap_old_code", rx, exp_stream(10'd4, 11));
      run_frame(0, 1'b1, 3'd3, 11, rx, all_oe, oe_end);
      check("snap_new_code", rx, exp_stream(10'h3FF, 11));
      data[3] = 10'd4;

      // Reset mid-MSB with csn held low: responder stays silent until csn cycles.
      c0   = conv_cnt;
      f0   = ferr_cnt;
      csn  = 1'b0;
      wait_clks(HALF);
      send_header(0, 1'b1, 3'd2, all_oe);
      for (int i = 0; i < 3; i++) sclk_cycle(1'b0, s, o);
      sclr = 1'b1;
      wait_clks(1);
      sclr = 1'b0;
      or_miso = 1'b0;
      or_oe   = 1'b0;
      for (int i = 0; i < 10; i++) begin
         sclk_cycle(1'b0, s, o);
         or_miso |= s;
         or_oe   |= o;
      end
      check("sclr_miso_quiet", 64'(or_miso), 64'd0);
      check("sclr_oe_off", 64'(or_oe), 64'd0);
      wait_clks(HALF);
      csn = 1'b1;
      wait_clks(HALF);
      check("sclr_no_frame_err", 64'(ferr_cnt - f0), 64'd0);
      check("sclr_conv_count", 64'(conv_cnt - c0), 64'd1);
      run_frame(0, 1'b1, 3'd2, 11, rx, all_oe, oe_end);
      check("sclr_next_frame", rx, exp_stream(10'd3, 11));
      check("sclr_next_conv_ch", 64'(conv_ch), 64'd2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
